pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. Consumes the ID-stage hazard requests (`stall`, `stallstall`), branch/jump resolution and multi-cycle mult/div issue. Produces the write-enable and flush controls for the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. Owns the two-cycle load-to-branch bubble, the fixed-latency mult/div freeze, and a stall performance counter.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/md_timer.sv | 27 ++
 rtl/pipe_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    MDWAIT = 2'd2
  } pipe_state_e;

  localparam int MD_LAT_DEF = 4;
  localparam int CNT_W_DEF  = 16;
  localparam int MD_CNT_W   = 4;

  // One bundle of pipeline register controls produced each cycle.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_flush;
    logic md_done;
  } pipe_ctl_t;

  // Canned control patterns for each kind of cycle.
  localparam pipe_ctl_t CTL_RUN    = '{pc_we:1'b1, ifid_we:1'b1, ifid_flush:1'b0, idex_we:1'b1,
                                       idex_flush:1'b0, exmem_flush:1'b0, md_done:1'b0};
  localparam pipe_ctl_t CTL_STALL  = '{pc_we:1'b0, ifid_we:1'b0, ifid_flush:1'b0, idex_we:1'b1,
                                       idex_flush:1'b1, exmem_flush:1'b0, md_done:1'b0};
  localparam pipe_ctl_t CTL_BR     = '{pc_we:1'b1, ifid_we:1'b1, ifid_flush:1'b1, idex_we:1'b1,
                                       idex_flush:1'b0, exmem_flush:1'b0, md_done:1'b0};
  localparam pipe_ctl_t CTL_MDWAIT = '{pc_we:1'b0, ifid_we:1'b0, ifid_flush:1'b0, idex_we:1'b0,
                                       idex_flush:1'b0, exmem_flush:1'b1, md_done:1'b0};
  localparam pipe_ctl_t CTL_MDDONE = '{pc_we:1'b0, ifid_we:1'b0, ifid_flush:1'b0, idex_we:1'b0,
                                       idex_flush:1'b0, exmem_flush:1'b0, md_done:1'b1};
  localparam pipe_ctl_t CTL_RST    = '{pc_we:1'b0, ifid_we:1'b0, ifid_flush:1'b1, idex_we:1'b0,
                                       idex_flush:1'b1, exmem_flush:1'b1, md_done:1'b0};

endpackage

// File: rtl/md_timer.sv
// Loadable 4-bit down-counter with zero flag; times the mult/div freeze.
module md_timer
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [MD_CNT_W-1:0] load_val,
  input  logic                dec,
  output logic [MD_CNT_W-1:0] cnt,
  output logic                zero
);

  // Count register: reset wins, then load, then decrement (stops at zero).
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  // Zero flag marks the final MDWAIT cycle.
  always_comb zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: PC / IF-ID / ID-EX / EX-MEM enables and
// flushes, load-to-branch double bubble, mult/div freeze, stall counter.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             stallstall,
  input  logic             br_taken,
  input  logic             md_start,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             md_done,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [MD_CNT_W-1:0] md_cnt;
  logic                md_zero;
  logic                md_load;
  logic                md_dec;
  pipe_ctl_t           ctl;

  // Mult/div issues only from RUN when nothing of higher priority is pending.
  always_comb begin
    md_load = (state_q == RUN) && !stall && !br_taken && md_start;
    md_dec  = (state_q == MDWAIT);
  end

  md_timer u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (md_load),
    .load_val (MD_LOAD),
    .dec      (md_dec),
    .cnt      (md_cnt),
    .zero     (md_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next-state: stall outranks branch outranks mult/div issue.
  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN: begin
        if (stall)         state_d = stallstall ? HOLD : RUN;
        else if (br_taken) state_d = RUN;
        else if (md_start) state_d = MDWAIT;
        else               state_d = RUN;
      end
      HOLD:    state_d = RUN;
      MDWAIT:  state_d = md_zero ? RUN : MDWAIT;
      default: state_d = RUN;  // 2'd3 is unreachable; recover
    endcase
  end

  // Output decode: reset forces a full flush; otherwise pick by state/request.
  always_comb begin
    ctl = CTL_RUN;
    if (rst) begin
      ctl = CTL_RST;
    end else begin
      case (state_q)
        RUN: begin
          if (stall)         ctl = CTL_STALL;
          else if (br_taken) ctl = CTL_BR;
          else               ctl = CTL_RUN;  // md_start issues like a normal advance
        end
        HOLD:    ctl = CTL_STALL;
        MDWAIT:  ctl = md_zero ? CTL_MDDONE : CTL_MDWAIT;
        default: ctl = CTL_STALL;  // freeze front end for the recovery cycle
      endcase
    end
  end

  // Unpack the control bundle onto the ports.
  always_comb begin
    pc_we       = ctl.pc_we;
    ifid_we     = ctl.ifid_we;
    ifid_flush  = ctl.ifid_flush;
    idex_we     = ctl.idex_we;
    idex_flush  = ctl.idex_flush;
    exmem_flush = ctl.exmem_flush;
    md_done     = ctl.md_done;
    state       = state_q;
  end

  // Stall performance counter: counts frozen-PC cycles, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (!pc_we && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with an expected-value queue checked each cycle.
module tb_pipe_ctrl;

  localparam int MD_LAT = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0, stallstall = 1'b0, br_taken = 1'b0, md_start = 1'b0;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, md_done;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  pipe_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .stallstall(stallstall),
    .br_taken(br_taken), .md_start(md_start), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .md_done(md_done), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Expected control vectors {pc_we,ifid_we,ifid_flush,idex_we,idex_flush,exmem_flush,md_done}
  localparam logic [6:0] E_RUN = 7'b1101000;
  localparam logic [6:0] E_STL = 7'b0001100;
  localparam logic [6:0] E_BR  = 7'b1111000;
  localparam logic [6:0] E_MDW = 7'b0000010;
  localparam logic [6:0] E_MDD = 7'b0000001;
  localparam logic [6:0] E_RST = 7'b0010110;

  typedef struct {
    logic [6:0]       ctl;
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  exp_t             sb[$];
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  // One cycle: drive inputs after the edge, queue expectation, compare mid-cycle.
  task automatic step(input string tag, input logic r, input logic s, input logic ss,
                      input logic br, input logic md, input logic [6:0] ectl,
                      input logic [1:0] est);
    exp_t e, g;
    logic [6:0] obs;
    @(posedge clk);
    #1;
    rst = r; stall = s; stallstall = ss; br_taken = br; md_start = md;
    e.ctl = ectl; e.st = est; e.cnt = exp_cnt; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    obs = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, md_done};
    checks++;
    assert (obs === g.ctl) else begin
      errors++;
      $error("FAIL %s ctl observed=%b expected=%b", g.tag, obs, g.ctl);
    end
    checks++;
    assert (state === g.st) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", g.tag, state, g.st);
    end
    checks++;
    assert (stall_cnt === g.cnt) else begin
      errors++;
      $error("FAIL %s stall_cnt observed=%h expected=%h", g.tag, stall_cnt, g.cnt);
    end
    // Account for the coming edge in the counter expectation.
    if (r)                                    exp_cnt = '0;
    else if (!ectl[6] && exp_cnt != '1)       exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    // Reset held two cycles.
    step("rst0", 1, 0, 0, 0, 0, E_RST, 2'd0);
    step("rst1", 1, 0, 0, 0, 0, E_RST, 2'd0);
    step("run0", 0, 0, 0, 0, 0, E_RUN, 2'd0);

    // Single-cycle stall.
    step("stall",   0, 1, 0, 0, 0, E_STL, 2'd0);
    step("stall_x", 0, 0, 0, 0, 0, E_RUN, 2'd0);

    // Load-to-beq double bubble; HOLD ignores inputs.
    step("ss_req",  0, 1, 1, 0, 0, E_STL, 2'd0);
    step("ss_hold", 0, 0, 0, 1, 1, E_STL, 2'd1);
    step("ss_x",    0, 0, 0, 0, 0, E_RUN, 2'd0);

    // Branch masked by stall, then taken.
    step("br_stl", 0, 1, 0, 1, 0, E_STL, 2'd0);
    step("br_tk",  0, 0, 0, 1, 0, E_BR,  2'd0);
    step("br_x",   0, 0, 0, 0, 0, E_RUN, 2'd0);

    // md_start under stall is ignored.
    step("md_stl", 0, 1, 0, 0, 1, E_STL, 2'd0);
    step("md_stx", 0, 0, 0, 0, 0, E_RUN, 2'd0);

    // Branch outranks md_start.
    step("md_br",  0, 0, 0, 1, 1, E_BR,  2'd0);
    step("md_brx", 0, 0, 0, 0, 0, E_RUN, 2'd0);

    // Mult/div freeze: 3 waiting cycles then done; inputs ignored in MDWAIT.
    step("md_iss", 0, 0, 0, 0, 1, E_RUN, 2'd0);
    step("md_w1",  0, 1, 1, 1, 1, E_MDW, 2'd2);
    step("md_w2",  0, 0, 0, 1, 0, E_MDW, 2'd2);
    step("md_w3",  0, 0, 0, 0, 0, E_MDW, 2'd2);
    step("md_dn",  0, 0, 0, 0, 1, E_MDD, 2'd2);
    step("md_x",   0, 0, 0, 0, 0, E_RUN, 2'd0);

    // Reset in second MDWAIT cycle aborts with no md_done.
    step("mr_iss", 0, 0, 0, 0, 1, E_RUN, 2'd0);
    step("mr_w1",  0, 0, 0, 0, 0, E_MDW, 2'd2);
    step("mr_rst", 1, 0, 0, 0, 0, E_RST, 2'd2);
    for (int i = 0; i < MD_LAT + 1; i++)
      step("mr_run", 0, 0, 0, 0, 0, E_RUN, 2'd0);

    // Reset during HOLD aborts to RUN.
    step("hr_req", 0, 1, 1, 0, 0, E_STL, 2'd0);
    step("hr_rst", 1, 0, 0, 0, 0, E_RST, 2'd1);
    step("hr_x",   0, 0, 0, 0, 0, E_RUN, 2'd0);

    // Counter saturation: stall for 2^CNT_W+5 cycles.
    @(posedge clk);
    #1;
    stall = 1'b1; stallstall = 1'b0; br_taken = 1'b0; md_start = 1'b0;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      @(posedge clk);
      if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    end
    step("sat_stl", 0, 1, 0, 0, 0, E_STL, 2'd0);
    step("sat_run", 0, 0, 0, 0, 0, E_RUN, 2'd0);
    checks++;
    assert (stall_cnt === {CNT_W{1'b1}}) else begin
      errors++;
      $error("FAIL sat_hold stall_cnt observed=%h expected=%h", stall_cnt, {CNT_W{1'b1}});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
